// File: rtl/sha256_stream_ctrl.sv
// SHA-256 stream controller: buffers a 512-bit block, feeds the expander, collects the digest
// and returns it to the transmitter as OUT_WIDTH-bit beats, chaining multi-block messages.
module sha256_stream_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH    = 8,
    parameter int unsigned BLOCK_WORDS  = 16,
    parameter int unsigned DIGEST_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    output logic                  me_valid_o,
    output logic [DATA_WIDTH-1:0] me_data_o,
    output logic                  me_first_o,
    input  logic                  mc_valid_i,
    input  logic [DATA_WIDTH-1:0] mc_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int unsigned DigBits = DATA_WIDTH * DIGEST_WORDS;
    localparam int unsigned Beats   = DigBits / OUT_WIDTH;
    localparam int unsigned WcW     = $clog2(BLOCK_WORDS);
    localparam int unsigned DcW     = $clog2(DIGEST_WORDS);
    localparam int unsigned KW      = (Beats > 1) ? $clog2(Beats) : 1;

    localparam logic [WcW-1:0] WLast = WcW'(BLOCK_WORDS - 1);
    localparam logic [DcW-1:0] DLast = DcW'(DIGEST_WORDS - 1);
    localparam logic [KW-1:0]  KLast = KW'(Beats - 1);

    typedef enum logic [2:0] {StLoad, StFeed, StWait, StCollect, StSend} state_e;

    state_e                state_q;
    logic [WcW-1:0]        wcnt_q, fcnt_q;
    logic [DcW-1:0]        dcnt_q;
    logic [KW-1:0]         k_q;
    logic                  first_q, last_q, init_q;
    logic [DATA_WIDTH-1:0] blk_q [BLOCK_WORDS];
    logic [DigBits-1:0]    dig_q;
    logic                  me_valid_q, me_first_q;
    logic [DATA_WIDTH-1:0] me_data_q;
    logic                  out_valid_q, out_last_q;
    logic [OUT_WIDTH-1:0]  out_data_q;

    logic [WcW-1:0]     fcnt_inc;
    logic [KW-1:0]      k_inc;
    logic [DigBits-1:0] dig_in, dig_shift;

    // Digest words shift in from the bottom so H0 ends up in the top bits after the last word.
    assign dig_in    = {dig_q[DigBits-DATA_WIDTH-1:0], mc_data_i};
    assign dig_shift = dig_q << OUT_WIDTH;
    assign fcnt_inc  = fcnt_q + 1'b1;
    assign k_inc     = k_q + 1'b1;

    // init_q keeps in_ready low until the first clock after reset release.
    assign in_ready_o = init_q && (state_q == StLoad);
    assign busy_o     = (state_q != StLoad) || (wcnt_q != '0);

    assign me_valid_o  = me_valid_q;
    assign me_data_o   = me_data_q;
    assign me_first_o  = me_first_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            wcnt_q      <= '0;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            k_q         <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            init_q      <= 1'b0;
            dig_q       <= '0;
            me_valid_q  <= 1'b0;
            me_data_q   <= '0;
            me_first_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) blk_q[i] <= '0;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                StLoad: begin
                    if (in_valid_i && in_ready_o) begin
                        blk_q[wcnt_q] <= in_data_i;
                        if (wcnt_q == WLast) begin
                            last_q     <= in_last_i;
                            wcnt_q     <= '0;
                            fcnt_q     <= '0;
                            me_valid_q <= 1'b1;
                            me_data_q  <= blk_q[0];
                            me_first_q <= first_q;
                            state_q    <= StFeed;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                StFeed: begin
                    if (fcnt_q == WLast) begin
                        me_valid_q <= 1'b0;
                        me_data_q  <= '0;
                        me_first_q <= 1'b0;
                        fcnt_q     <= '0;
                        state_q    <= StWait;
                    end else begin
                        fcnt_q    <= fcnt_inc;
                        me_data_q <= blk_q[fcnt_inc];
                    end
                end
                StWait: begin
                    if (mc_valid_i) begin
                        dig_q   <= dig_in;
                        dcnt_q  <= DcW'(1);
                        state_q <= StCollect;
                    end
                end
                StCollect: begin
                    if (mc_valid_i) begin
                        dig_q <= dig_in;
                        if (dcnt_q == DLast) begin
                            dcnt_q <= '0;
                            if (last_q) begin
                                first_q     <= 1'b1;
                                k_q         <= '0;
                                out_valid_q <= 1'b1;
                                out_data_q  <= dig_in[DigBits-1 -: OUT_WIDTH];
                                out_last_q  <= (KLast == '0);
                                state_q     <= StSend;
                            end else begin
                                first_q <= 1'b0;
                                state_q <= StLoad;
                            end
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (out_valid_q && out_ready_i) begin
                        if (k_q == KLast) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            k_q         <= '0;
                            wcnt_q      <= '0;
                            fcnt_q      <= '0;
                            dcnt_q      <= '0;
                            state_q     <= StLoad;
                        end else begin
                            k_q        <= k_inc;
                            dig_q      <= dig_shift;
                            out_data_q <= dig_shift[DigBits-1 -: OUT_WIDTH];
                            out_last_q <= (k_inc == KLast);
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Directed bench for sha256_stream_ctrl: three instances (8/32/64-bit beats) share stimulus;
// the bench plays the packer and compression roles and checks feed and beat streams.
module tb_sha256_stream_ctrl;

    localparam logic [255:0] AbcDig =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DigA =
        256'h0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a1111222233334444;
    localparam logic [255:0] DigB =
        256'hcafebabedeadbeef0badf00d8badf00d13579bdf2468ace0fedcba9801234567;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, mc_valid, out_ready;
    logic [31:0] in_data, mc_data;

    logic        in_ready8, me_valid8, me_first8, out_valid8, out_last8, busy8;
    logic [31:0] me_data8;
    logic [7:0]  out_data8;
    logic        in_ready32, me_valid32, me_first32, out_valid32, out_last32, busy32;
    logic [31:0] me_data32;
    logic [31:0] out_data32;
    logic        in_ready64, me_valid64, me_first64, out_valid64, out_last64, busy64;
    logic [31:0] me_data64;
    logic [63:0] out_data64;

    always #5 clk = ~clk;

    sha256_stream_ctrl #(.OUT_WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready8), .in_data_i(in_data), .in_last_i(in_last),
        .me_valid_o(me_valid8), .me_data_o(me_data8), .me_first_o(me_first8),
        .mc_valid_i(mc_valid), .mc_data_i(mc_data),
        .out_valid_o(out_valid8), .out_ready_i(out_ready), .out_data_o(out_data8),
        .out_last_o(out_last8), .busy_o(busy8)
    );

    sha256_stream_ctrl #(.OUT_WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready32), .in_data_i(in_data), .in_last_i(in_last),
        .me_valid_o(me_valid32), .me_data_o(me_data32), .me_first_o(me_first32),
        .mc_valid_i(mc_valid), .mc_data_i(mc_data),
        .out_valid_o(out_valid32), .out_ready_i(out_ready), .out_data_o(out_data32),
        .out_last_o(out_last32), .busy_o(busy32)
    );

    sha256_stream_ctrl #(.OUT_WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready64), .in_data_i(in_data), .in_last_i(in_last),
        .me_valid_o(me_valid64), .me_data_o(me_data64), .me_first_o(me_first64),
        .mc_valid_i(mc_valid), .mc_data_i(mc_data),
        .out_valid_o(out_valid64), .out_ready_i(out_ready), .out_data_o(out_data64),
        .out_last_o(out_last64), .busy_o(busy64)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  blk [16];
    logic [255:0] exp_dig;
    int           b8, b32, b64, stalls;
    bit           any_out, bp_en, stall8, hold_last8;
    logic [7:0]   hold8;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_beat(input string tag, input int ow, input int k, input logic [63:0] d,
                            input logic l);
        logic [255:0] sh;
        logic [63:0]  e;
        sh = exp_dig << (ow * k);
        e  = sh[255:192] >> (64 - ow);
        check_eq(tag, d, e);
        check_eq({tag, "_last"}, 64'(l), 64'(k == 256 / ow - 1));
    endtask

    // Output monitor: per-beat data/last on each handshake, plus hold-while-stalled on u_dut8.
    initial begin
        stall8 = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid8 || out_valid32 || out_valid64) any_out = 1;
                if (stall8) begin
                    check_eq("hold8_valid", 64'(out_valid8), 64'd1);
                    check_eq("hold8_data", 64'(out_data8), 64'(hold8));
                    check_eq("hold8_last", 64'(out_last8), 64'(hold_last8));
                end
                if (out_valid8 && out_ready) begin
                    mon_beat("beat8", 8, b8, 64'(out_data8), out_last8);
                    b8++;
                end
                if (out_valid32 && out_ready) begin
                    mon_beat("beat32", 32, b32, 64'(out_data32), out_last32);
                    b32++;
                end
                if (out_valid64 && out_ready) begin
                    mon_beat("beat64", 64, b64, out_data64, out_last64);
                    b64++;
                end
                stall8     = out_valid8 && !out_ready;
                hold8      = out_data8;
                hold_last8 = out_last8;
                if (stall8) stalls++;
            end else begin
                stall8 = 0;
            end
        end
    end

    // out_ready pattern 1,0,0,1 when backpressure is enabled, else held high.
    initial begin
        int ph;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic fill_pattern(input int seed);
        for (int i = 0; i < 16; i++) blk[i] = 32'(seed) * 32'h1000_0001 + 32'(i) * 32'h0101_0101;
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready8) check_eq("in_ready_wait", 64'(in_ready8), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_block(input bit last, input bit gappy, input bit last5);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            push_word(blk[i], (i == 15) ? last : (last5 && i == 5));
            if (i == 0) check_eq("busy_loading", 64'(busy8), 64'd1);
            if (gappy && i < 15) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_feed(input bit exp_first, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check_eq("me_valid", 64'(me_valid8), 64'd1);
            check_eq("me_data", 64'(me_data8), 64'(blk[i]));
            check_eq("me_first", 64'(me_first8), 64'(exp_first));
        end
        if (ncyc == 16) begin
            @(negedge clk);
            check_eq("me_valid_end", 64'(me_valid8), 64'd0);
            check_eq("in_ready_feed", 64'(in_ready8), 64'd0);
        end
    endtask

    task automatic give_digest(input logic [255:0] d, input bit gappy);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            mc_valid = 1'b1;
            mc_data  = d[255-32*i -: 32];
            @(posedge clk);
            #1;
            mc_valid = 1'b0;
            if (gappy) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_beats();
        int t;
        t = 0;
        while (!(b8 == 32 && b32 == 8 && b64 == 4) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check_eq("beats8", 64'(b8), 64'd32);
        check_eq("beats32", 64'(b32), 64'd8);
        check_eq("beats64", 64'(b64), 64'd4);
        check_eq("idle_busy", 64'(busy8), 64'd0);
        check_eq("idle_in_ready", 64'(in_ready8), 64'd1);
    endtask

    task automatic clear_counts();
        b8 = 0;
        b32 = 0;
        b64 = 0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_in_ready"}, 64'(in_ready8), 64'd0);
        check_eq({tag, "_me_valid"}, 64'(me_valid8), 64'd0);
        check_eq({tag, "_me_data"}, 64'(me_data8), 64'd0);
        check_eq({tag, "_me_first"}, 64'(me_first8), 64'd0);
        check_eq({tag, "_out_valid"}, 64'({out_valid8, out_valid32, out_valid64}), 64'd0);
        check_eq({tag, "_out_data"}, out_data64 | 64'(out_data32) | 64'(out_data8), 64'd0);
        check_eq({tag, "_out_last"}, 64'({out_last8, out_last32, out_last64}), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy8), 64'd0);
    endtask

    task automatic run_abc(input bit exp_first);
        fill_abc();
        exp_dig = AbcDig;
        clear_counts();
        push_block(1'b1, 1'b0, 1'b0);
        check_feed(exp_first, 16);
        give_digest(AbcDig, 1'b0);
        wait_beats();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        mc_valid = 1'b0;
        mc_data = '0;
        bp_en = 0;
        any_out = 0;
        stalls = 0;
        clear_counts();
        exp_dig = AbcDig;

        // Reset state, then in_ready one clock after release.
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("in_ready_after_reset", 64'(in_ready8), 64'd1);

        // Single "abc" block at full throughput on all three beat widths.
        run_abc(1'b1);

        // Same block under 1,0,0,1 backpressure.
        bp_en = 1;
        run_abc(1'b1);
        bp_en = 0;
        check_eq("stalls_seen", 64'(stalls > 0), 64'd1);

        // Two-block message: stray mc_valid in LOAD, 50% input duty, in_last on word 5.
        @(posedge clk);
        #1;
        mc_valid = 1'b1;
        mc_data  = 32'hdeadbeef;
        @(posedge clk);
        #1;
        mc_valid = 1'b0;
        fill_pattern(1);
        clear_counts();
        push_block(1'b0, 1'b1, 1'b1);
        check_feed(1'b1, 16);
        any_out = 0;
        give_digest(DigA, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("no_out_after_block1", 64'(any_out), 64'd0);
        check_eq("load_after_block1", 64'(in_ready8), 64'd1);
        fill_pattern(2);
        exp_dig = DigB;
        push_block(1'b1, 1'b0, 1'b0);
        check_feed(1'b0, 16);
        give_digest(DigB, 1'b1);
        wait_beats();
        run_abc(1'b1);

        // Reset mid-FEED of a chained block; next block must start a fresh message.
        fill_pattern(3);
        clear_counts();
        push_block(1'b0, 1'b0, 1'b0);
        check_feed(1'b1, 16);
        give_digest(DigA, 1'b0);
        fill_pattern(4);
        push_block(1'b1, 1'b0, 1'b0);
        check_feed(1'b0, 8);
        rst_n = 1'b0;
        #1;
        check_zero("midfeed_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("in_ready_after_midreset", 64'(in_ready8), 64'd1);
        check_eq("beats_after_midreset", 64'(b8 + b32 + b64), 64'd0);
        run_abc(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
